// File: rtl/seq_detector_1011.sv
// seq_detector_1011: overlapping 1011 serial pattern detector with saturating detection counter
module seq_detector_1011 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             valid,
  input  logic             clr,
  output logic             det,
  output logic [CNT_W-1:0] count,
  output logic             sat,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S10 = 2'b10, S101 = 2'b11} state_t;
  state_t cur, nxt;
  logic hit;
  // valid gates everything, so an unknown din while idle never reaches state
  always_comb begin
    hit = valid && cur == S101 && din;
    nxt = !valid ? cur :
          din    ? (cur == S10 ? S101 : S1) :
                   ((cur == S1 || cur == S101) ? S10 : S0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur   <= S0;
      det   <= 1'b0;
      count <= '0;
    end else begin
      cur   <= nxt;
      det   <= hit;
      count <= clr ? '0 : (hit && !sat) ? count + 1'b1 : count;
    end
  end
  assign sat   = count == {CNT_W{1'b1}};
  assign state = cur;
endmodule

// File: tb/tb_seq_detector_1011.sv
// tb_seq_detector_1011: directed and random checks of two detector widths against a bit-history model
module tb_seq_detector_1011;
  logic clk = 1'b0, reset = 1'b1, din = 1'b0, valid = 1'b0, clr = 1'b0;
  logic det, det2, sat, sat2;
  logic [7:0] count;
  logic [1:0] count2, state, state2;
  int checks = 0, errors = 0;
  logic [3:0] hist;
  int nb, cnt8, cnt2;
  logic edet;

  seq_detector_1011 dut (.clk(clk), .reset(reset), .din(din), .valid(valid), .clr(clr),
    .det(det), .count(count), .sat(sat), .state(state));
  seq_detector_1011 #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .din(din), .valid(valid), .clr(clr),
    .det(det2), .count(count2), .sat(sat2), .state(state2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected state is the longest suffix of sampled bits that is a prefix of 1011
  function automatic logic [1:0] exp_state(input logic [3:0] h, input int n);
    return (n >= 3 && h[2:0] == 3'b101) ? 2'd3 :
           (n >= 2 && h[1:0] == 2'b10)  ? 2'd2 :
           (n >= 1 && h[0])             ? 2'd1 : 2'd0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".det"}, det, edet);
    chk({tag, ".count"}, count, cnt8);
    chk({tag, ".sat"}, sat, cnt8 == 255);
    chk({tag, ".state"}, state, exp_state(hist, nb));
    chk({tag, ".det2"}, det2, edet);
    chk({tag, ".count2"}, count2, cnt2);
    chk({tag, ".sat2"}, sat2, cnt2 == 3);
    chk({tag, ".state2"}, state2, exp_state(hist, nb));
  endtask

  task automatic model_reset();
    hist = '0; nb = 0; cnt8 = 0; cnt2 = 0; edet = 1'b0;
  endtask

  task automatic step(input logic d, input logic v, input logic c, input string tag);
    @(negedge clk);
    din = d; valid = v; clr = c;
    @(posedge clk);
    if (v === 1'b1) begin
      hist = {hist[2:0], d};
      if (nb < 4) nb++;
    end
    edet = v === 1'b1 && nb == 4 && hist == 4'b1011;
    cnt8 = c ? 0 : (edet && cnt8 < 255) ? cnt8 + 1 : cnt8;
    cnt2 = c ? 0 : (edet && cnt2 < 3) ? cnt2 + 1 : cnt2;
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #3 check_all("rst_async");
    #5 check_all("rst_during");
    #2 reset = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0, "idle_after_rst");
    step(1, 1, 0, "p1"); step(0, 1, 0, "p1"); step(1, 1, 0, "p1"); step(1, 1, 0, "p1_det");
    step(0, 1, 0, "p1_after");
    step(1, 1, 0, "ov"); step(1, 1, 0, "ov");
    step(0, 1, 0, "ov"); step(1, 1, 0, "ov"); step(1, 1, 0, "ov_det2");
    step(1, 1, 0, "ov_after");
    step(1, 1, 1, "clr");
    step(0, 1, 0, "gap"); step(1, 1, 0, "gap"); step(0, 1, 0, "gap"); step(1, 1, 0, "gap");
    repeat (3) step(1, 0, 0, "gap_hold");
    step(1'bx, 0, 0, "x_hold");
    step(1, 1, 0, "gap_det");
    step(0, 1, 0, "sat"); step(1, 1, 0, "sat"); step(1, 1, 0, "sat");
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, "sat_run"); step(1, 1, 0, "sat_run"); step(1, 1, 0, "sat_run");
    end
    step(0, 1, 0, "clr_det"); step(1, 1, 0, "clr_det"); step(1, 1, 1, "clr_det_hit");
    step(0, 1, 0, "mid"); step(1, 1, 0, "mid");
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("mid_rst_async");
    #1 reset = 1'b0;
    step(1, 1, 0, "post_rst_one");
    step(0, 0, 0, "post_rst_idle");
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, "rand");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detector_1011.md
SEQ_DETECTOR_1011 -- requirements
Module: seq_detector_1011

Interface
REQ-001 Parameter: CNT_W, default 8, width of the detection counter (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
REQ-004 Port: din  input  1  serial data bit, driven by the upstream D flip-flop Q output.
REQ-005 Port: valid  input  1  din is sampled only on rising edges where valid=1.
REQ-006 Port: clr  input  1  synchronous clear of count and sat; does not affect the FSM.
REQ-007 Port: det  output  1  registered one-cycle pulse marking completion of pattern 1011.
REQ-008 Port: count  output  CNT_W  number of detections since reset or clr, saturating.
REQ-009 Port: sat  output  1  high while count equals 2^CNT_W-1.
REQ-010 Port: state  output  2  current FSM state encoding (debug visibility).

Function
REQ-011 The FSM SHALL have four states: S0=2'b00 (no prefix), S1=2'b01 ("1"), S10=2'b10 ("10"), S101=2'b11 ("101").
REQ-012 On a rising edge with valid=1, transitions SHALL be:
- S0: din=1 -> S1; din=0 -> S0.
- S1: din=1 -> S1; din=0 -> S10.
- S10: din=1 -> S101; din=0 -> S0.
- S101: din=1 -> S1 (overlap); din=0 -> S10.
REQ-013 On a rising edge with valid=0, state, det-source and count SHALL hold; det SHALL be 0 on the following cycle.
REQ-014 det SHALL be 1 for exactly the cycle after an edge where valid=1, state=S101 and din=1; otherwise det SHALL be 0.
REQ-015 Detection latency: det SHALL rise at the clock edge that samples the final '1' of the pattern (i.e., it is visible one cycle after that bit is presented).
REQ-016 Overlapping patterns SHALL be detected: stream 1011011 SHALL produce two det pulses.
REQ-017 count SHALL increment by 1 on the same edge at which det is set to 1.
REQ-018 count SHALL saturate at 2^CNT_W-1 without wrap; further detections SHALL still pulse det.
REQ-019 sat SHALL be combinationally equal to (count == 2^CNT_W-1).
REQ-020 clr=1 at an edge SHALL set count to 0 and take priority over a simultaneous increment; det and the FSM SHALL behave as if clr were 0.
REQ-021 din and valid SHALL be treated as 0/1 only; X on din with valid=0 SHALL NOT alter any state.

Reset
REQ-022 While reset=1: state=S0, det=0, count=0, sat=0, asserted asynchronously without waiting for clk.
REQ-023 Reset asserted mid-pattern (e.g., in S101) SHALL discard the partial match; the first det after release requires a full new 1011.
REQ-024 Upon reset deassertion, the first rising edge with valid=1 SHALL be processed normally.

Verification
REQ-025 Reset pulse of 10 ns with clk running -> state=00, det=0, count=0 during and after reset, until valid input arrives.
REQ-026 valid=1 every cycle, din stream 1,0,1,1 -> det=1 for exactly one cycle after the 4th bit, count=1, state=01.
REQ-027 Stream 1,0,1,1,0,1,1 (overlap) -> two det pulses, 3 cycles apart; count=2.
REQ-028 Stream 1,0,1 then valid=0 for 3 cycles with din=1, then valid=1, din=1 -> no det during the gap; det after the resumed bit; count=1.
REQ-029 CNT_W=2, seven back-to-back overlapping patterns -> count sticks at 3, sat=1, det still pulses; clr=1 coincident with a det -> count=0 next cycle, det=1.
REQ-030 Reset asserted asynchronously between edges while state=S101 -> state=00 immediately; after release, din=1 alone produces no det.
